// File: rtl/dem_noise_shaper_pkg.sv
// Shared constants and types for the second-order error-feedback requantizer
// that sits in front of the switching tree.
//   INPUT_WIDTH  : switching-tree input width. It is also the requantizer output width.
//   NS_IN_WIDTH  : width of the wide sample that is fed into the requantizer
//   NS_FRAC      : number of LSBs that are truncated away
//   OUT_MAX/MIN  : clip limits of the requantized output
//   ns_err_t     : truncation-error register type (unsigned, NS_FRAC bits)
package dem_noise_shaper_pkg;

    localparam int INPUT_WIDTH = 16;
    localparam int NS_IN_WIDTH = 24;
    localparam int NS_FRAC     = NS_IN_WIDTH - INPUT_WIDTH;

    localparam logic signed [INPUT_WIDTH-1:0] OUT_MAX = {1'b0, {(INPUT_WIDTH-1){1'b1}}};
    localparam logic signed [INPUT_WIDTH-1:0] OUT_MIN = {1'b1, {(INPUT_WIDTH-1){1'b0}}};

    typedef logic [NS_FRAC-1:0] ns_err_t;

endpackage

// File: rtl/dem_noise_shaper_lfsr16.sv
// ns_lfsr16: 16-bit Fibonacci LFSR with taps 16,14,13,11. It is used as the
// dither source for the requantizer. The LFSR advances once per cycle while
// en_i is high. Reset is synchronous and active-high, and it loads 16'hACE1.
//   clk_i, reset_i : clock and synchronous reset
//   en_i           : advance enable
//   state_o        : current LFSR state (bit 0 is the newest bit)
module ns_lfsr16 (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        en_i,
    output logic [15:0] state_o
);

    logic fb;

    assign fb = state_o[15] ^ state_o[13] ^ state_o[12] ^ state_o[10];

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_o <= 16'hACE1;
        end else if (en_i) begin
            state_o <= {state_o[14:0], fb};
        end
    end

endmodule

// File: rtl/dem_noise_shaper.sv
// dem_noise_shaper: second-order error-feedback requantizer.
// It truncates a wide signed sample to OUT_WIDTH bits. The truncation error is
// shaped with the transfer function (1 - z^-1)^2, so that the error moves to
// high frequency. Values that fall outside the output range are clipped, and
// each clip is counted.
//
// Optional feature: when the macro NS_DITHER_EN is defined, an LFSR dither bit
// is added at weight 2^(FRAC-2). When the macro is undefined, the block is
// fully deterministic.
//
// Ports:
//   clk_i, reset_i    : clock and synchronous active-high reset
//   x_in_i            : signed input sample (IN_WIDTH bits)
//   in_valid_i        : input valid
//   in_ready_o        : input ready. This is combinational from the output
//                       side only.
//   x_out_o           : requantized sample (OUT_WIDTH bits), sent to the
//                       switching tree
//   out_valid_o       : output valid
//   out_ready_i       : output ready
//   sat_o             : set when the sample held in x_out_o was clipped
//   sat_count_o       : saturating count of clipped samples
//   sat_clr_i         : clear for sat_count_o
module dem_noise_shaper
    import dem_noise_shaper_pkg::*;
#(
    parameter int IN_WIDTH  = NS_IN_WIDTH,
    parameter int OUT_WIDTH = INPUT_WIDTH,
    parameter int FRAC      = IN_WIDTH - OUT_WIDTH   // must be >= 2
) (
    input  logic                        clk_i,
    input  logic                        reset_i,
    input  logic signed [IN_WIDTH-1:0]  x_in_i,
    input  logic                        in_valid_i,
    output logic                        in_ready_o,
    output logic signed [OUT_WIDTH-1:0] x_out_o,
    output logic                        out_valid_o,
    input  logic                        out_ready_i,
    output logic                        sat_o,
    output logic [15:0]                 sat_count_o,
    input  logic                        sat_clr_i
);

    // The accumulator has 3 guard bits. That is enough for x + 2*e1 - e2
    // without wrap.
    localparam int VW = IN_WIDTH + 3;
    localparam int QW = VW - FRAC;

    localparam logic signed [QW-1:0] Q_MAX = {{(QW-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [QW-1:0] Q_MIN = {{(QW-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

    logic [FRAC-1:0]             e1, e2, e_nxt;
    logic signed [VW-1:0]        v;
    logic signed [QW-1:0]        q;
    logic signed [OUT_WIDTH-1:0] y;
    logic                        sat;
    logic                        accept;
    logic [15:0]                 sat_cnt, sat_cnt_nxt;

    assign in_ready_o  = !out_valid_o || out_ready_i;
    assign accept      = in_valid_i && in_ready_o;
    assign sat_count_o = sat_cnt;

`ifdef NS_DITHER_EN
    logic [15:0] lfsr;

    ns_lfsr16 u_lfsr (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .en_i    (accept),
        .state_o (lfsr)
    );
`endif

    always_comb begin
        v = VW'(x_in_i) + VW'({e1, 1'b0}) - VW'(e2);
`ifdef NS_DITHER_EN
        v = v + (VW'(lfsr[0]) << (FRAC - 2));
`endif
        // Taking the upper bits is an arithmetic shift right, which floors
        // the value. The low bits that remain are the non-negative error.
        q     = $signed(v[VW-1:FRAC]);
        e_nxt = v[FRAC-1:0];
        sat   = 1'b0;
        y     = q[OUT_WIDTH-1:0];
        // On a clip, the error is dropped instead of being fed back.
        // Otherwise a large error would keep the loop pinned at the rail.
        if (q > Q_MAX) begin
            y     = {1'b0, {(OUT_WIDTH-1){1'b1}}};
            sat   = 1'b1;
            e_nxt = '0;
        end else if (q < Q_MIN) begin
            y     = {1'b1, {(OUT_WIDTH-1){1'b0}}};
            sat   = 1'b1;
            e_nxt = '0;
        end
    end

    always_comb begin
        sat_cnt_nxt = sat_cnt;
        if (sat_clr_i) begin
            sat_cnt_nxt = (accept && sat) ? 16'd1 : 16'd0;
        end else if (accept && sat && sat_cnt != 16'hFFFF) begin
            sat_cnt_nxt = sat_cnt + 16'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            x_out_o     <= '0;
            out_valid_o <= 1'b0;
            sat_o       <= 1'b0;
            e1          <= '0;
            e2          <= '0;
            sat_cnt     <= '0;
        end else begin
            if (accept) begin
                x_out_o     <= y;
                sat_o       <= sat;
                e1          <= e_nxt;
                e2          <= e1;
                out_valid_o <= 1'b1;
            end else if (out_ready_i) begin
                out_valid_o <= 1'b0;
            end
            sat_cnt <= sat_cnt_nxt;
        end
    end

endmodule

// File: tb/tb_dem_noise_shaper.sv
module tb_dem_noise_shaper;

    logic               clk = 1'b0;
    logic               reset_i;
    logic signed [23:0] x_in_i;
    logic               in_valid_i;
    logic               in_ready_o;
    logic signed [15:0] x_out_o;
    logic               out_valid_o;
    logic               out_ready_i;
    logic               sat_o;
    logic [15:0]        sat_count_o;
    logic               sat_clr_i;

    dem_noise_shaper dut (
        .clk_i       (clk),
        .reset_i     (reset_i),
        .x_in_i      (x_in_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .x_out_o     (x_out_o),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .sat_o       (sat_o),
        .sat_count_o (sat_count_o),
        .sat_clr_i   (sat_clr_i)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model. It works on plain integers and applies the
    // requantizer rules directly.
    longint m_e1, m_e2, m_out, m_cnt;
    bit     m_valid, m_sat;

    task automatic chk(input string tag, input longint got, input longint exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic m_reset();
        m_e1 = 0; m_e2 = 0; m_out = 0; m_cnt = 0; m_valid = 0; m_sat = 0;
    endtask

    // One clock cycle. The inputs are driven at the negedge, and the DUT is
    // compared against the model at the next negedge.
    task automatic step(input logic signed [23:0] x, input bit vld, input bit rdy, input bit clr);
        longint v, q, e;
        bit     acc, s;
        x_in_i = x; in_valid_i = vld; out_ready_i = rdy; sat_clr_i = clr;
        #1;
        chk("in_ready", in_ready_o, (!m_valid || rdy));
        acc = vld && (!m_valid || rdy);
        s   = 0;
        if (acc) begin
            v = longint'(x) + 2 * m_e1 - m_e2;
            e = v % 256;
            if (e < 0) e += 256;
            q = (v - e) / 256;
            if (q > 32767) begin
                m_out = 32767; s = 1; e = 0;
            end else if (q < -32768) begin
                m_out = -32768; s = 1; e = 0;
            end else begin
                m_out = q;
            end
            m_sat = s; m_e2 = m_e1; m_e1 = e; m_valid = 1;
        end else if (rdy) begin
            m_valid = 0;
        end
        if (clr) m_cnt = (acc && s) ? 1 : 0;
        else if (acc && s && m_cnt < 65535) m_cnt++;
        @(posedge clk);
        @(negedge clk);
        chk("out_valid", out_valid_o, m_valid);
        chk("x_out", x_out_o, m_out);
        chk("sat", sat_o, m_sat);
        chk("sat_count", sat_count_o, m_cnt);
    endtask

    task automatic do_reset();
        reset_i = 1'b1; in_valid_i = 0; out_ready_i = 1; sat_clr_i = 0; x_in_i = '0;
        @(posedge clk);
        @(negedge clk);
        reset_i = 1'b0;
        m_reset();
        chk("rst_x_out", x_out_o, 0);
        chk("rst_out_valid", out_valid_o, 0);
        chk("rst_sat", sat_o, 0);
        chk("rst_sat_count", sat_count_o, 0);
    endtask

    initial begin
        longint pat[4];
        longint hold;
        logic signed [23:0] rx;
        pat[0] = 0; pat[1] = 1; pat[2] = 1; pat[3] = 0;

        do_reset();

        // Exact input: every output sample is 1 and there is no error.
        for (int i = 0; i < 6; i++) begin
            step(24'sh000100, 1, 1, 0);
            chk("exact_x", x_out_o, 1);
            chk("exact_sat", sat_o, 0);
        end

        // Half-LSB input: the output pattern is 0,1,1,0.
        do_reset();
        for (int i = 0; i < 8; i++) begin
            step(24'sh000080, 1, 1, 0);
            chk("half_x", x_out_o, pat[i % 4]);
        end

        // Reset in the middle of the half-LSB run, then restart.
        step(24'sh000080, 1, 1, 0);
        step(24'sh000080, 1, 1, 0);
        do_reset();
        for (int i = 0; i < 4; i++) begin
            step(24'sh000080, 1, 1, 0);
            chk("rst_restart_x", x_out_o, pat[i]);
        end

        // Positive clip: sat is set on samples 2, 5 and 8.
        do_reset();
        for (int i = 0; i < 8; i++) begin
            step(24'sh7FFFFF, 1, 1, 0);
            chk("clip_x", x_out_o, 32767);
            chk("clip_sat", sat_o, (i % 3 == 1) ? 1 : 0);
        end
        chk("clip_count", sat_count_o, 3);

        // Clear on the same cycle as a saturating accept (sample 11), then a
        // clear on its own.
        step(24'sh7FFFFF, 1, 1, 0);
        step(24'sh7FFFFF, 1, 1, 0);
        step(24'sh7FFFFF, 1, 1, 1);
        chk("clr_sat_count", sat_count_o, 1);
        step(24'sh000000, 0, 1, 1);
        chk("clr_alone_count", sat_count_o, 0);

        // Backpressure in the middle of the half-LSB stream.
        do_reset();
        step(24'sh000080, 1, 1, 0);
        step(24'sh000080, 1, 1, 0);
        hold = x_out_o;
        for (int i = 0; i < 5; i++) begin
            step(24'sh000080, 1, 0, 0);
            chk("bp_in_ready", in_ready_o, 0);
            chk("bp_x_hold", x_out_o, hold);
        end
        for (int i = 2; i < 8; i++) begin
            step(24'sh000080, 1, 1, 0);
            chk("bp_resume_x", x_out_o, pat[i % 4]);
        end

        // Count saturates at 16'hFFFF. The count is preloaded, because
        // reaching it through real clips would take too long.
        force dut.sat_cnt = 16'hFFFF;
        m_cnt = 65535;
        step(24'sh000000, 0, 1, 0);
        release dut.sat_cnt;
        for (int i = 0; i < 6; i++) step(24'sh7FFFFF, 1, 1, 0);
        chk("cnt_stick", sat_count_o, 16'hFFFF);

        // Randomized traffic with random handshakes and values that reach
        // into the clip regions.
        do_reset();
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 3))
                0: rx = 24'($urandom);
                1: rx = 24'sh7FFFFF - 24'($urandom_range(0, 1023));
                2: rx = 24'sh800000 + 24'($urandom_range(0, 1023));
                default: rx = 24'($signed(12'($urandom)));
            endcase
            step(rx, ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 31) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
